data_sram_responder: RTL and testbench



---
 rtl/data_sram_responder.sv | 91 +++++++++
 tb/tb_data_sram_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// data_sram_responder: byte-writable data RAM plus LED/timer/scratch/compare MMIO window,
// 1-cycle registered read-before-write responses.
module data_sram_responder #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] MMIO_BASE  = 32'hBFAF_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    output logic        timer_irq
);
    logic [31:0] mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] idx;
    logic [15:0] off;
    logic hit, mmio_wr, irq_set, irq_clr;
    logic [31:0] ram_q, mmio_q, mmio_d, timer_q, timer_d, scratch_q, scratch_d, cmp_q, cmp_d;
    logic [15:0] led_q, led_d;
    logic ram_sel_q, irq_q, irq_d;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i+:8] = be[i] ? new_v[8*i+:8] : old_v[8*i+:8];
        return r;
    endfunction

    assign hit     = data_sram_addr[31:16] == MMIO_BASE[31:16];
    assign idx     = data_sram_addr[DEPTH_LOG2+1:2];
    assign off     = data_sram_addr[15:0];
    assign mmio_wr = data_sram_en && hit && |data_sram_we;
    // compare against the registered timer; a same-cycle clear loses to a set
    assign irq_set = cmp_q != '0 && timer_q == cmp_q;
    assign irq_clr = mmio_wr && off == 16'h10 && data_sram_we[0];

    always_comb begin
        led_d     = (mmio_wr && off == 16'h0) ?
                    {data_sram_we[1] ? data_sram_wdata[15:8] : led_q[15:8],
                     data_sram_we[0] ? data_sram_wdata[7:0]  : led_q[7:0]} : led_q;
        timer_d   = (mmio_wr && off == 16'h4) ? merge(timer_q, data_sram_wdata, data_sram_we)
                                              : timer_q + 32'd1;
        scratch_d = (mmio_wr && off == 16'h8) ? merge(scratch_q, data_sram_wdata, data_sram_we)
                                              : scratch_q;
        cmp_d     = (mmio_wr && off == 16'hC) ? merge(cmp_q, data_sram_wdata, data_sram_we) : cmp_q;
        irq_d     = irq_set | (irq_q & ~irq_clr);
        mmio_d    = off == 16'h0  ? {16'h0, led_q} :
                    off == 16'h4  ? timer_q :
                    off == 16'h8  ? scratch_q :
                    off == 16'hC  ? cmp_q :
                    off == 16'h10 ? {31'h0, irq_q} : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q     <= '0;
            timer_q   <= '0;
            scratch_q <= '0;
            cmp_q     <= '0;
            irq_q     <= 1'b0;
            mmio_q    <= '0;
            ram_sel_q <= 1'b0;
        end else begin
            led_q     <= led_d;
            timer_q   <= timer_d;
            scratch_q <= scratch_d;
            cmp_q     <= cmp_d;
            irq_q     <= irq_d;
            if (data_sram_en) begin
                ram_sel_q <= !hit;
                if (hit) mmio_q <= mmio_d;
            end
        end
    end

    // RAM has no reset so it maps onto block RAM; output register holds until next RAM access
    always_ff @(posedge clk) begin
        if (data_sram_en && !hit) begin
            ram_q <= mem[idx];
            for (int i = 0; i < 4; i++)
                if (data_sram_we[i]) mem[idx][8*i+:8] <= data_sram_wdata[8*i+:8];
        end
    end

    assign data_sram_rdata = ram_sel_q ? ram_q : mmio_q;
    assign led             = led_q;
    assign timer_irq       = irq_q;
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: directed plus randomized bus traffic checked every cycle against
// a word-array / register-variable reference model of the responder.
module tb_data_sram_responder;
    localparam int DL    = 12;
    localparam int DEPTH = 1 << DL;

    logic        clk = 1'b0, resetn = 1'b0, en = 1'b0;
    logic [3:0]  we = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic [15:0] led;
    logic        irq;

    int vectors = 0, miscompares = 0;
    logic [31:0] ram_m [DEPTH];
    logic [31:0] rd_m, led_m, tmr_m, scr_m, cmp_m;
    logic        irq_m;
    int pool [5] = '{0, 1, 'h40, 'h41, 'hFFF};
    int mm   [7] = '{0, 4, 8, 'hC, 'h10, 'h14, 'h20};

    always #5 clk = ~clk;

    data_sram_responder #(.DEPTH_LOG2(DL), .MMIO_BASE(32'hBFAF_0000)) dut (
        .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_we(we),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata),
        .led(led), .timer_irq(irq)
    );

    function automatic logic [31:0] bytes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i+:8] = n[8*i+:8];
        return r;
    endfunction

    function automatic logic [31:0] ram_addr(input int idx);
        logic [31:0] a = $urandom;
        a[DL+1:2] = idx[DL-1:0];
        if (a[31:16] == 16'hBFAF) a[31] = 1'b0;
        return a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rd_m = 0; led_m = 0; tmr_m = 0; scr_m = 0; cmp_m = 0; irq_m = 0;
    endtask

    task automatic model_edge(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] nt = tmr_m + 1;
        logic set = cmp_m != 0 && tmr_m == cmp_m;
        logic clr = 1'b0;
        int i;
        if (e) begin
            if (a[31:16] == 16'hBFAF) begin
                case (a[15:0])
                    16'h0:  begin rd_m = led_m; led_m = bytes(led_m, d, w) & 32'hFFFF; end
                    16'h4:  begin rd_m = tmr_m; if (w != 0) nt = bytes(tmr_m, d, w); end
                    16'h8:  begin rd_m = scr_m; scr_m = bytes(scr_m, d, w); end
                    16'hC:  begin rd_m = cmp_m; cmp_m = bytes(cmp_m, d, w); end
                    16'h10: begin rd_m = {31'h0, irq_m}; clr = w[0]; end
                    default: rd_m = 0;
                endcase
            end else begin
                i = int'((a >> 2) % 32'(DEPTH));
                rd_m = ram_m[i];
                ram_m[i] = bytes(ram_m[i], d, w);
            end
        end
        tmr_m = nt;
        irq_m = set | (irq_m & ~clr);
    endtask

    task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en = e; we = w; addr = a; wdata = d;
        @(posedge clk);
        model_edge(e, w, a, d);
        #1;
        if (!$isunknown(rd_m)) chk("rdata", rdata, rd_m);
        chk("led", {16'h0, led}, led_m);
        chk("irq", {31'h0, irq}, {31'h0, irq_m});
    endtask

    initial begin
        logic [31:0] ra, rd;
        logic [3:0]  rw;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_led", {16'h0, led}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        resetn = 1'b1;
        foreach (pool[k]) cyc(1, 4'hF, ram_addr(pool[k]), $urandom);

        cyc(1, 4'hF, 32'h1C00_0100, 32'hDEAD_BEEF);
        cyc(1, 4'h0, 32'h1C00_0100, 32'h0);
        chk("ram_read", rdata, 32'hDEAD_BEEF);
        cyc(0, 4'h0, 32'h0, 32'h0);
        cyc(0, 4'h0, 32'h0, 32'h0);
        chk("ram_hold", rdata, 32'hDEAD_BEEF);

        cyc(1, 4'hF, 32'h1C00_0104, 32'h1122_3344);
        cyc(1, 4'b0101, 32'h1C00_0104, 32'hAABB_CCDD);
        chk("bytewr_old", rdata, 32'h1122_3344);
        cyc(1, 4'h0, 32'h1C00_0104, 32'h0);
        chk("bytewr_new", rdata, 32'h11BB_33DD);

        cyc(1, 4'hF, 32'h0, 32'h5A5A_5A5A);
        cyc(1, 4'h0, 32'(1 << (DL + 2)), 32'h0);
        chk("alias", rdata, 32'h5A5A_5A5A);

        cyc(1, 4'hF, 32'hBFAF_0000, 32'hFFFF_1234);
        chk("led_out", {16'h0, led}, 32'h1234);
        cyc(1, 4'h0, 32'hBFAF_0000, 32'h0);
        chk("led_read", rdata, 32'h0000_1234);
        cyc(1, 4'hF, 32'hBFAF_0020, 32'hFFFF_FFFF);
        cyc(1, 4'h0, 32'hBFAF_0020, 32'h0);
        chk("unmapped", rdata, 32'h0);
        cyc(1, 4'b1000, 32'hBFAF_0008, 32'hAB00_0000);
        cyc(1, 4'h0, 32'hBFAF_0008, 32'h0);
        chk("scratch", rdata, 32'hAB00_0000);

        cyc(1, 4'hF, 32'hBFAF_0004, 32'hFFFF_FFFE);
        cyc(0, 4'h0, 32'h0, 32'h0);
        cyc(0, 4'h0, 32'h0, 32'h0);
        cyc(1, 4'h0, 32'hBFAF_0004, 32'h0);
        chk("timer_wrap", rdata, 32'h0);

        cyc(1, 4'hF, 32'hBFAF_000C, 32'h10);
        cyc(1, 4'hF, 32'hBFAF_0004, 32'h0);
        repeat (16) cyc(0, 4'h0, 32'h0, 32'h0);
        chk("irq_before", {31'h0, irq}, 32'h0);
        cyc(0, 4'h0, 32'h0, 32'h0);
        chk("irq_rise", {31'h0, irq}, 32'h1);
        repeat (3) cyc(0, 4'h0, 32'h0, 32'h0);
        chk("irq_sticky", {31'h0, irq}, 32'h1);
        cyc(1, 4'b0001, 32'hBFAF_0010, 32'h1);
        chk("irq_clear", {31'h0, irq}, 32'h0);
        cyc(1, 4'hF, 32'hBFAF_0004, 32'hF);
        cyc(0, 4'h0, 32'h0, 32'h0);
        cyc(1, 4'b0001, 32'hBFAF_0010, 32'h1);
        chk("irq_set_wins", {31'h0, irq}, 32'h1);
        cyc(1, 4'b0001, 32'hBFAF_0010, 32'h1);
        chk("irq_clear2", {31'h0, irq}, 32'h0);

        repeat (400) begin
            ra = $urandom_range(0, 1) ? ram_addr(pool[$urandom_range(0, 4)])
                                      : {16'hBFAF, 16'(mm[$urandom_range(0, 6)])};
            rw = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            rd = $urandom_range(0, 1) ? 32'($urandom_range(0, 40)) : 32'($urandom);
            cyc($urandom_range(0, 9) != 0, rw, ra, rd);
        end

        cyc(1, 4'hF, ram_addr('hFFF), 32'hCAFE_F00D);
        en = 1'b0; we = '0;
        #2 resetn = 1'b0;
        #1;
        chk("async_rdata", rdata, 32'h0);
        chk("async_led", {16'h0, led}, 32'h0);
        chk("async_irq", {31'h0, irq}, 32'h0);
        model_reset();
        @(posedge clk);
        #1 resetn = 1'b1;
        cyc(1, 4'h0, 32'hBFAF_0004, 32'h0);
        chk("timer_after_rst", rdata, 32'h0);
        cyc(1, 4'h0, ram_addr('hFFF), 32'h0);
        chk("ram_kept", rdata, 32'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
